// File: rtl/sparse_arith_pkg.sv
// Shared arithmetic helpers for the structured-sparsity pruner:
// norm width sizing, sign-safe absolute value and a generic keep-mask type.
package sparse_arith_pkg;

    // Upper bound on keep-mask width carried through generic code.
    localparam int MAX_MASK_BITS = 64;

    // One bit per block; bit set means the block survives pruning.
    typedef logic [MAX_MASK_BITS-1:0] block_mask_t;

    // Width that holds the sum of BLOCK_SIZE magnitudes of A_WIDTH-bit signed values.
    function automatic int norm_width(input int a_width, input int block_size);
        return a_width + $clog2(block_size) + 1;
    endfunction

    // Magnitude of a sign-extended element. Computed at 32 bits so the most-negative
    // element maps to 2^(A_WIDTH-1) instead of wrapping back to itself.
    function automatic int abs_sat(input int x);
        return (x < 0) ? -x : x;
    endfunction

endpackage

// File: rtl/block_topk_select.sv
// Combinational top-K block selector: BLOCK_NUM norms in, keep mask out.
// A block is kept when fewer than KEEP_NUM blocks outrank it; equal norms
// are broken towards the lower block index, so exactly KEEP_NUM bits are set.
module block_topk_select #(
    parameter int BLOCK_NUM  = 2,
    parameter int NORM_WIDTH = 10,
    parameter int KEEP_NUM   = 1
) (
    input  logic [BLOCK_NUM-1:0][NORM_WIDTH-1:0] norms,
    output logic [BLOCK_NUM-1:0]                 keep
);

    for (genvar gi = 0; gi < BLOCK_NUM; gi++) begin : g_rank
        int rank_next;

        // Count blocks that beat this one: larger norm, or equal norm at a lower index.
        always_comb begin
            rank_next = 0;
            for (int j = 0; j < BLOCK_NUM; j++) begin
                if ((norms[j] > norms[gi]) || ((j < gi) && (norms[j] == norms[gi]))) begin
                    rank_next = rank_next + 1;
                end
            end
        end

        assign keep[gi] = (rank_next < KEEP_NUM);
    end

endmodule

// File: rtl/sparse_block_pruner.sv
// Streaming structured-sparsity pruner for the sparse matmul A port.
// Stage 1 computes per-block L1 norms; stage 2 keeps the largest blocks of
// each row, zeroes the rest and emits a per-row keep mask.
// Optional build macro: SPARSE_PRUNE_STATS_EN adds stat_beats / stat_lost counters.
module sparse_block_pruner
    import sparse_arith_pkg::*;
#(
    parameter int A_COMPUTE_DIM0   = 4,
    parameter int A_COMPUTE_DIM1   = 2,
    parameter int A_WIDTH          = 8,
    parameter int BLOCK_NUM        = 2,
    parameter int SPARSE_BLOCK_NUM = 1
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [A_COMPUTE_DIM0*A_COMPUTE_DIM1-1:0][A_WIDTH-1:0] in_data,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    output logic [A_COMPUTE_DIM0*A_COMPUTE_DIM1-1:0][A_WIDTH-1:0] out_data,
    output logic [BLOCK_NUM*A_COMPUTE_DIM1-1:0]                 out_mask,
    output logic                                                out_valid,
    input  logic                                                out_ready
`ifdef SPARSE_PRUNE_STATS_EN
    ,
    output logic [31:0]                                         stat_beats,
    output logic [31:0]                                         stat_lost
`endif
);

    localparam int DATA_NUM            = A_COMPUTE_DIM0 * A_COMPUTE_DIM1;
    localparam int BLOCK_SIZE          = A_COMPUTE_DIM0 / BLOCK_NUM;
    localparam int NONSPARSE_BLOCK_NUM = BLOCK_NUM - SPARSE_BLOCK_NUM;
    localparam int NORM_WIDTH          = norm_width(A_WIDTH, BLOCK_SIZE);
    localparam int MASK_BITS           = BLOCK_NUM * A_COMPUTE_DIM1;

    // Handshake: each stage advances when it is empty or the stage after it advances.
    logic s1_adv;
    logic s2_adv;

    logic                                  s1_valid_reg;
    logic [DATA_NUM-1:0][A_WIDTH-1:0]      s1_data_reg;
    logic [MASK_BITS-1:0][NORM_WIDTH-1:0]  s1_norm_reg;
    logic [MASK_BITS-1:0][NORM_WIDTH-1:0]  norm_next;

    logic [MASK_BITS-1:0]                  keep_next;
    logic [DATA_NUM-1:0][A_WIDTH-1:0]      pruned_next;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1 combinational: L1 norm of every block of every row of the incoming beat.
    always_comb begin
        norm_next = '0;
        for (int r = 0; r < A_COMPUTE_DIM1; r++) begin
            for (int b = 0; b < BLOCK_NUM; b++) begin
                for (int k = 0; k < BLOCK_SIZE; k++) begin
                    norm_next[r*BLOCK_NUM + b] = norm_next[r*BLOCK_NUM + b]
                        + NORM_WIDTH'(abs_sat(int'($signed(in_data[r*A_COMPUTE_DIM0 + b*BLOCK_SIZE + k]))));
                end
            end
        end
    end

    // Stage 1 register: raw data travels with its block norms.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_norm_reg  <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_data_reg <= in_data;
                s1_norm_reg <= norm_next;
            end
        end
    end

    // Stage 2 combinational: one top-K selector per row.
    for (genvar gi = 0; gi < A_COMPUTE_DIM1; gi++) begin : g_row_sel
        block_topk_select #(
            .BLOCK_NUM  (BLOCK_NUM),
            .NORM_WIDTH (NORM_WIDTH),
            .KEEP_NUM   (NONSPARSE_BLOCK_NUM)
        ) u_select (
            .norms (s1_norm_reg[gi*BLOCK_NUM +: BLOCK_NUM]),
            .keep  (keep_next[gi*BLOCK_NUM +: BLOCK_NUM])
        );
    end

    // Zero every element whose block was pruned; kept elements pass bit-exact.
    for (genvar gi = 0; gi < DATA_NUM; gi++) begin : g_gate
        localparam int ROW = gi / A_COMPUTE_DIM0;
        localparam int BLK = (gi % A_COMPUTE_DIM0) / BLOCK_SIZE;
        assign pruned_next[gi] = keep_next[ROW*BLOCK_NUM + BLK] ? s1_data_reg[gi] : '0;
    end

    // Stage 2 register: output holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data <= pruned_next;
                out_mask <= keep_next;
            end
        end
    end

`ifdef SPARSE_PRUNE_STATS_EN
    localparam int LOST_WIDTH = $clog2(MASK_BITS + 1);

    logic [LOST_WIDTH-1:0] lost_next;
    logic [LOST_WIDTH-1:0] lost_reg;
    logic [32:0]           lost_sum_next;
    logic                  out_fire;

    assign out_fire = out_valid && out_ready;

    // Pruned blocks that actually carried energy (nonzero norm) in the stage-2 beat.
    always_comb begin
        lost_next = '0;
        for (int i = 0; i < MASK_BITS; i++) begin
            if (!keep_next[i] && (s1_norm_reg[i] != '0)) begin
                lost_next = lost_next + LOST_WIDTH'(1);
            end
        end
        lost_sum_next = {1'b0, stat_lost} + 33'(lost_reg);
    end

    // Lost-block count rides along with the output beat it describes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lost_reg <= '0;
        end else if (s2_adv && s1_valid_reg) begin
            lost_reg <= lost_next;
        end
    end

    // Saturating statistics, updated once per output handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_beats <= '0;
            stat_lost  <= '0;
        end else if (out_fire) begin
            if (stat_beats != '1) begin
                stat_beats <= stat_beats + 32'd1;
            end
            stat_lost <= lost_sum_next[32] ? '1 : lost_sum_next[31:0];
        end
    end
`endif

endmodule
